// File: rtl/kmeans_iter_ctrl.sv
// Iteration sequencer for the k-means classify/update datapath: clear, stream points,
// drain the classify pipe, walk the centroid updater, repeat until stable or out of iterations.
module kmeans_iter_ctrl #(
    parameter int addrWidth    = 8,
    parameter int centroid_num = 8,
    parameter int pipe_latency = 3,
    parameter int iter_width   = 4,
    parameter int max_iter     = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [addrWidth:0]              num_points,
    output logic                            mem_rd_en,
    output logic [addrWidth-1:0]            mem_addr,
    output logic                            enable_2_regs,
    output logic                            regs_reset_n,
    output logic                            upd_req,
    output logic [$clog2(centroid_num)-1:0] upd_sel,
    input  logic                            upd_ack,
    input  logic                            upd_changed,
    output logic                            busy,
    output logic                            done,
    output logic                            converged,
    output logic [iter_width-1:0]           iter_cnt
);
    localparam int SEL_W = $clog2(centroid_num);
    localparam logic [addrWidth:0]    NP_MAX   = {1'b1, {addrWidth{1'b0}}};
    localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(centroid_num - 1);
    localparam logic [iter_width-1:0] ITER_MAX = iter_width'(max_iter);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_UPDATE, S_CHECK, S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [addrWidth:0]      np_q, np_d;
    logic [addrWidth-1:0]    addr_q, addr_d;
    logic [pipe_latency-1:0] vld_q, vld_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    changed_q, changed_d;
    logic [iter_width-1:0]   iter_q, iter_d;
    logic                    conv_q, conv_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d   = state_q;
        np_d      = np_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        changed_d = changed_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        done_d    = 1'b0;
        // Valid shadow of the read strobe; its last tap marks a point arriving at the accumulators.
        vld_d[0]  = (state_q == S_STREAM);
        for (int i = 1; i < pipe_latency; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    np_d    = (num_points > NP_MAX) ? NP_MAX : num_points;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    addr_d  = '0;
                    state_d = (num_points == '0) ? S_FINISH : S_CLEAR;
                end
            end
            S_CLEAR: begin
                changed_d = 1'b0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if ({1'b0, addr_q} == np_q - (addrWidth+1)'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave once the final enable is on the output tap and nothing follows it.
                if (vld_d == '0) begin
                    sel_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (upd_ack) begin
                    changed_d = changed_q | upd_changed;
                    if (sel_q == SEL_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                iter_d = iter_q + 1'b1;
                if (!changed_q) begin
                    conv_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (iter_d == ITER_MAX) begin
                    state_d = S_FINISH;
                end else begin
                    addr_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (abort) begin
            state_d = S_IDLE;
            vld_d   = '0;
            done_d  = 1'b0;
            np_d    = np_q;
            iter_d  = iter_q;
            conv_d  = conv_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            np_q      <= '0;
            addr_q    <= '0;
            vld_q     <= '0;
            sel_q     <= '0;
            changed_q <= 1'b0;
            iter_q    <= '0;
            conv_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            np_q      <= np_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
            iter_q    <= iter_d;
            conv_q    <= conv_d;
            done_q    <= done_d;
        end
    end

    assign mem_rd_en     = (state_q == S_STREAM);
    assign mem_addr      = addr_q;
    assign enable_2_regs = vld_q[pipe_latency-1];
    assign regs_reset_n  = (state_q != S_CLEAR);
    assign upd_req       = (state_q == S_UPDATE);
    assign upd_sel       = sel_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign converged     = conv_q;
    assign iter_cnt      = iter_q;
endmodule
